instr_mem_block: RTL and testbench
==================================

Name: instr_mem_block

Overview:
Program memory that the sequencer reads from. The host side writes device operations as pairs of a 4-bit device number and a 16-bit argument. The sequencer side pops one entry per rising edge of mblock_en, sees the entry on dev_no/data_bus, and uses mblock_valid to see whether unread entries remain. mblock_clr rewinds the read pointer so that a stored program can be replayed without being rewritten.

Parameters:
ADDR_W, 6, address width; storage depth DEPTH = 2**ADDR_W entries of 20 bits ({dev, data}).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  host write strobe; one entry per cycle while high
wr_dev  in  4  device number to store
wr_data  in  16  argument to store
prog_clr  in  1  erase program: length and read pointer go to 0
full  out  1  high when stored length = DEPTH
count  out  ADDR_W+1  stored program length (wr_ptr)
rd_index  out  ADDR_W+1  current read pointer (debug)
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a pop was attempted while not valid
mblock_en  in  1  sequencer pop request; level, rising-edge detected
mblock_clr  in  1  rewind request; level-sensitive
mblock_valid  out  1  unread entry available
dev_no  out  4  device number of the last popped entry
data_bus  out  16  argument of the last popped entry

Behaviour:
- Reset (async): wr_ptr=0, rd_ptr=0, en_d=0, dev_no=0, data_bus=0, overflow=0, underflow=0. Memory array is not reset.
- Combinational outputs, derived from registers only:
  - mblock_valid = (rd_ptr < wr_ptr)
  - full = (wr_ptr == DEPTH)
  - count = wr_ptr
  - rd_index = rd_ptr
- Write, per cycle:
  - prog_clr high: wr_ptr<=0, rd_ptr<=0, overflow<=0, underflow<=0. Any wr_en in the same cycle is dropped. prog_clr has top priority.
  - Else wr_en && !full: mem[wr_ptr]<={wr_dev,wr_data}, wr_ptr<=wr_ptr+1.
  - Else wr_en && full: no store, overflow<=1.
  - Writes are accepted regardless of mblock_clr or sequencer activity (appending while the program runs is legal).
- Pop detect: en_d<=mblock_en every cycle, including during mblock_clr and prog_clr. pop = mblock_en && !en_d.
  - A level held high for several cycles pops exactly once.
- Read, per cycle, in priority order:
  - prog_clr: handled above.
  - mblock_clr high: rd_ptr<=0; pop is ignored; dev_no/data_bus hold their values.
  - pop && mblock_valid: {dev_no,data_bus}<=mem[rd_ptr], rd_ptr<=rd_ptr+1.
  - pop && !mblock_valid: outputs hold, underflow<=1.
- Latency: the entry appears on dev_no/data_bus at the first clock edge that samples mblock_en high. It is stable from then until the next pop. The sequencer examines dev_no two edges after it raises mblock_en.
- mblock_valid updates on the same edge as the pop, so the sequencer sees the post-pop value the next time it checks.
- Rewind timing: mblock_clr sampled high at edge N gives rd_ptr=0 after N. mblock_valid is then correct for a sample at edge N+1, even if mblock_clr drops at edge N.
- Write and pop in the same cycle:
  - mblock_valid is evaluated on pre-edge pointers. If empty, the pop is ignored (underflow set) and the write still lands.
  - If rd_ptr==wr_ptr-1, the pop reads the existing entry, not the one being written.
- Pointers never wrap. rd_ptr saturates at wr_ptr by construction, and wr_ptr saturates at DEPTH.
- Read port is synchronous, inferable as block RAM: registered output, one read address per cycle.

Test Plan:
- Reset, then write 3 entries {1,0x0100},{3,0x0A05},{6,0x0000}, then pulse mblock_en high 2 cycles three times -> count=3. Each pop yields dev_no/data_bus = the stored pairs in order, one edge after the rise. mblock_valid falls after the third pop. rd_index=3.
- mblock_en held high 10 cycles with 3 entries stored -> exactly one pop: rd_index=1, dev_no=1, data_bus=0x0100.
- After the program is exhausted, one cycle of mblock_clr=1 -> rd_index=0, mblock_valid=1 at the next edge. Re-popping returns {1,0x0100} again. dev_no is unchanged while clr is high.
- Fill DEPTH entries, then one more write -> full=1, count=DEPTH, overflow=1, the last stored entry is unchanged. Then prog_clr -> count=0, full=0, overflow=0, mblock_valid=0.
- Pop on empty memory simultaneous with wr_en {4,0x1234} -> underflow=1, dev_no/data_bus unchanged, count=1. The next pop returns {4,0x1234}.
- Assert rst asynchronously mid-pop (between clock edges) -> all outputs 0 immediately. After release, a rising edge of mblock_en pops nothing and sets underflow=1.

Source files
------------

// File: rtl/instr_mem_block.sv
// Sequencer program memory: the host appends {device, argument} pairs and the
// sequencer pops one entry per rising edge of mblock_en, with rewind and erase.
module instr_mem_block #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_dev,
  input  logic [15:0]       wr_data,
  input  logic              prog_clr,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   rd_index,
  output logic              overflow,
  output logic              underflow,
  input  logic              mblock_en,
  input  logic              mblock_clr,
  output logic              mblock_valid,
  output logic [3:0]        dev_no,
  output logic [15:0]       data_bus
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [19:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            en_d;
  logic            pop;
  logic            wr_ok;

  // Pointers carry one extra bit so "full" (wr_ptr == DEPTH) is representable.
  assign mblock_valid = (rd_ptr < wr_ptr);
  assign full         = (wr_ptr == DEPTH_V);
  assign count        = wr_ptr;
  assign rd_index     = rd_ptr;
  assign pop          = mblock_en && !en_d;
  assign wr_ok        = wr_en && !full && !prog_clr;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // pointers and the registered read port are reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= {wr_dev, wr_data};
  end

  // NOTE: all state here uses non-blocking assignments, so a same-cycle write
  // and pop both see pre-edge pointers and the read returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      en_d      <= 1'b0;
      dev_no    <= '0;
      data_bus  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      en_d <= mblock_en;
      if (prog_clr) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en) begin
          if (!full) wr_ptr   <= wr_ptr + 1'b1;
          else       overflow <= 1'b1;
        end
        // Rewind wins over a pop; the last popped entry stays on the outputs.
        if (mblock_clr) begin
          rd_ptr <= '0;
        end else if (pop) begin
          if (mblock_valid) begin
            {dev_no, data_bus} <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr             <= rd_ptr + 1'b1;
          end else begin
            underflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_block.sv
// Directed bench for instr_mem_block: a queue model of stored entries feeds a
// scoreboard of expected pop results, compared with immediate assertions.
module tb_instr_mem_block;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, prog_clr, mblock_en, mblock_clr;
  logic [3:0]        wr_dev;
  logic [15:0]       wr_data;
  logic              full, overflow, underflow, mblock_valid;
  logic [ADDR_W:0]   count, rd_index;
  logic [3:0]        dev_no;
  logic [15:0]       data_bus;

  instr_mem_block #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dev(wr_dev), .wr_data(wr_data),
    .prog_clr(prog_clr), .full(full), .count(count), .rd_index(rd_index),
    .overflow(overflow), .underflow(underflow), .mblock_en(mblock_en),
    .mblock_clr(mblock_clr), .mblock_valid(mblock_valid), .dev_no(dev_no),
    .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [19:0] m_mem[$];
  logic [19:0] exp_q[$];
  int          m_rd  = 0;
  logic [19:0] m_last = '0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pop();
    if (m_rd < m_mem.size()) begin
      exp_q.push_back(m_mem[m_rd]);
      m_rd++;
    end else begin
      exp_q.push_back(m_last);
      m_unf = 1'b1;
    end
  endtask

  task automatic model_write(input logic [3:0] d, input logic [15:0] v);
    if (m_mem.size() < DEPTH) m_mem.push_back({d, v});
    else                      m_ovf = 1'b1;
  endtask

  task automatic model_reset();
    m_mem.delete();
    m_rd  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_pop(input string tag);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check(tag, 32'({dev_no, data_bus}), 32'(e));
    m_last = e;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_count"}, 32'(count), 32'(m_mem.size()));
    check({tag, "_rd_index"}, 32'(rd_index), 32'(m_rd));
    check({tag, "_valid"}, 32'(mblock_valid), 32'(m_rd < m_mem.size()));
    check({tag, "_full"}, 32'(full), 32'(m_mem.size() == DEPTH));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic do_write(input logic [3:0] d, input logic [15:0] v);
    wr_en = 1'b1; wr_dev = d; wr_data = v;
    model_write(d, v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_pop(input string tag, input int hi);
    mblock_en = 1'b1;
    model_pop();
    tick();
    check_pop(tag);
    repeat (hi - 1) tick();
    mblock_en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; prog_clr = 1'b0; mblock_en = 1'b0; mblock_clr = 1'b0;
    wr_dev = '0; wr_data = '0;
    #12;
    check("reset_dev", 32'({dev_no, data_bus}), 32'd0);
    check_regs("reset");
    rst = 1'b0;
    tick();

    // Basic program of three entries, popped with two-cycle pulses.
    do_write(4'd1, 16'h0100);
    do_write(4'd3, 16'h0A05);
    do_write(4'd6, 16'h0000);
    check_regs("written3");
    do_pop("pop1", 2);
    do_pop("pop2", 2);
    check_regs("after_pop2");
    do_pop("pop3", 2);
    check_regs("after_pop3");

    // One-cycle rewind: outputs hold, pointer returns to zero.
    mblock_clr = 1'b1;
    m_rd = 0;
    tick();
    check("clr_dev_hold", 32'({dev_no, data_bus}), 32'(m_last));
    mblock_clr = 1'b0;
    check_regs("after_clr");

    // Level held for ten cycles pops exactly once.
    do_pop("held_pop", 10);
    check_regs("after_held");

    // Pop the second entry, then pop the last while appending a new one.
    do_pop("pop_b", 1);
    mblock_en = 1'b1; wr_en = 1'b1; wr_dev = 4'd9; wr_data = 16'hBEEF;
    model_pop();
    model_write(4'd9, 16'hBEEF);
    tick();
    check_pop("pop_with_write");
    wr_en = 1'b0; mblock_en = 1'b0;
    tick();
    check_regs("pop_with_write");

    // Erase with a concurrent write: the write is dropped.
    prog_clr = 1'b1; wr_en = 1'b1; wr_dev = 4'd7; wr_data = 16'h7777;
    model_reset();
    tick();
    prog_clr = 1'b0; wr_en = 1'b0;
    check_regs("erase_with_write");

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) do_write(4'(i), 16'hA000 + 16'(i));
    check_regs("filled");
    do_write(4'hF, 16'hFFFF);
    check_regs("overflow");
    for (int i = 0; i < DEPTH; i++) do_pop($sformatf("drain_%0d", i), 1);
    check("last_entry", 32'({dev_no, data_bus}), 32'({4'(DEPTH - 1), 16'hA000 + 16'(DEPTH - 1)}));
    check_regs("drained");
    prog_clr = 1'b1;
    model_reset();
    tick();
    prog_clr = 1'b0;
    check_regs("erased");

    // Pop on empty coinciding with a write: underflow, write lands.
    mblock_en = 1'b1; wr_en = 1'b1; wr_dev = 4'd4; wr_data = 16'h1234;
    model_pop();
    model_write(4'd4, 16'h1234);
    tick();
    check_pop("empty_pop_hold");
    wr_en = 1'b0; mblock_en = 1'b0;
    tick();
    check_regs("empty_pop");
    do_pop("pop_after_underflow", 2);

    // Asynchronous reset between clock edges during a pop.
    do_write(4'd2, 16'h2222);
    mblock_en = 1'b1;
    model_pop();
    tick();
    check_pop("pop_before_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    m_last = '0;
    check("rst_async_dev", 32'({dev_no, data_bus}), 32'd0);
    check_regs("rst_async");
    mblock_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_pop("pop_after_rst", 1);
    check_regs("after_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
